// File: rtl/countdown_mmss.sv
// Loadable BCD mm:ss countdown timer. Decrements once per 1 Hz tick while
// running, pulses done on reaching 00:00 and holds there until reloaded.
module countdown_mmss (
  input  logic       reset,
  input  logic       clkin,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic       running,
  output logic       done,
  output logic       expired
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t     state, state_nxt;
  logic [7:0] min_nxt, sec_nxt;
  logic       done_nxt;
  logic       is_zero, is_one;

  function automatic logic [3:0] clamp_nib(input logic [3:0] v, input logic [3:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [7:0] sanitize(input logic [7:0] v);
    return {clamp_nib(v[7:4], 4'd5), clamp_nib(v[3:0], 4'd9)};
  endfunction

  // Per-nibble borrow chain; the top nibble never wraps because RUN holds a nonzero value.
  function automatic logic [15:0] decrement(input logic [15:0] v);
    logic [3:0] m10, m1, s10, s1;
    logic       b;
    {m10, m1, s10, s1} = v;
    b  = (s1 == 4'd0);
    s1 = b ? 4'd9 : s1 - 4'd1;
    if (b) begin
      b   = (s10 == 4'd0);
      s10 = b ? 4'd5 : s10 - 4'd1;
    end
    if (b) begin
      b  = (m1 == 4'd0);
      m1 = b ? 4'd9 : m1 - 4'd1;
    end
    if (b) m10 = m10 - 4'd1;
    return {m10, m1, s10, s1};
  endfunction

  assign is_zero = ({min, sec} == 16'h0000);
  assign is_one  = ({min, sec} == 16'h0001);

  always_comb begin
    state_nxt = state;
    min_nxt   = min;
    sec_nxt   = sec;
    done_nxt  = 1'b0;
    if (load) begin
      state_nxt = IDLE;
      min_nxt   = sanitize(load_min);
      sec_nxt   = sanitize(load_sec);
    end else if (stop) begin
      // stop absorbs start and tick in every state; it only acts in RUN
      if (state == RUN) state_nxt = PAUSE;
    end else if (start && (state == IDLE || state == PAUSE)) begin
      if (is_zero) begin
        state_nxt = EXPIRED;
        done_nxt  = 1'b1;
      end else begin
        state_nxt = RUN;
      end
    end else if (tick && state == RUN) begin
      {min_nxt, sec_nxt} = decrement({min, sec});
      if (is_one) begin
        state_nxt = EXPIRED;
        done_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      min     <= 8'h00;
      sec     <= 8'h00;
      running <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_nxt;
      min     <= min_nxt;
      sec     <= sec_nxt;
      running <= (state_nxt == RUN);
      done    <= done_nxt;
      expired <= (state_nxt == EXPIRED);
    end
  end

endmodule

// File: tb/tb_countdown_mmss.sv
// Bench for countdown_mmss: directed scenarios plus random traffic, every cycle
// compared against a total-seconds reference model.
module tb_countdown_mmss;

  logic       reset, clkin, tick, load, start, stop;
  logic [7:0] load_min, load_sec;
  logic [7:0] min, sec;
  logic       running, done, expired;

  countdown_mmss dut (
    .reset(reset), .clkin(clkin), .tick(tick), .load(load),
    .load_min(load_min), .load_sec(load_sec), .start(start), .stop(stop),
    .min(min), .sec(sec), .running(running), .done(done), .expired(expired)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 counting, 2 paused, 3 expired; value in seconds.
  int m_mode  = 0;
  int m_total = 0;
  bit m_done  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] t, o;
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic int sanit(input logic [7:0] x);
    int t, o;
    t = int'(x[7:4]);
    o = int'(x[3:0]);
    if (t > 5) t = 5;
    if (o > 9) o = 9;
    return t * 10 + o;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_total = 0; m_done = 0;
  endtask

  task automatic model_step(input bit ld, input logic [7:0] lm, input logic [7:0] ls,
                            input bit st, input bit sp, input bit tk);
    m_done = 0;
    if (ld) begin
      m_mode  = 0;
      m_total = sanit(lm) * 60 + sanit(ls);
    end else if (sp) begin
      if (m_mode == 1) m_mode = 2;
    end else if (st && (m_mode == 0 || m_mode == 2)) begin
      if (m_total == 0) begin m_mode = 3; m_done = 1; end
      else m_mode = 1;
    end else if (tk && m_mode == 1) begin
      m_total = m_total - 1;
      if (m_total == 0) begin m_mode = 3; m_done = 1; end
    end
  endtask

  task automatic compare_all();
    check("min", 32'(min), 32'(bcd(m_total / 60)));
    check("sec", 32'(sec), 32'(bcd(m_total % 60)));
    check("running", 32'(running), 32'(m_mode == 1));
    check("done", 32'(done), 32'(m_done));
    check("expired", 32'(expired), 32'(m_mode == 3));
  endtask

  task automatic step(input bit ld, input logic [7:0] lm, input logic [7:0] ls,
                      input bit st, input bit sp, input bit tk);
    load = ld; load_min = lm; load_sec = ls; start = st; stop = sp; tick = tk;
    @(posedge clkin);
    model_step(ld, lm, ls, st, sp, tk);
    #1;
    compare_all();
    load = 0; start = 0; stop = 0; tick = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 8'h00, 0, 0, 1);
  endtask

  initial begin
    reset = 1'b1; tick = 0; load = 0; start = 0; stop = 0;
    load_min = 8'h00; load_sec = 8'h00;
    model_reset();
    #12;
    compare_all();
    @(negedge clkin);
    reset = 1'b0;

    // 01:05 down to 00:00
    step(1, 8'h01, 8'h05, 0, 0, 0);
    step(0, 8'h00, 8'h00, 1, 0, 0);
    ticks(65);
    check("t65_expired", 32'(expired), 32'd1);
    ticks(2);

    // minute and tens borrows
    step(1, 8'h10, 8'h00, 0, 0, 0);
    step(0, 8'h00, 8'h00, 1, 0, 0);
    ticks(1);
    check("borrow_min", 32'({min, sec}), 32'h0959);
    step(1, 8'h00, 8'h10, 0, 0, 0);
    step(0, 8'h00, 8'h00, 1, 0, 0);
    ticks(1);
    check("borrow_sec", 32'({min, sec}), 32'h0009);

    // pause and resume
    step(1, 8'h00, 8'h03, 0, 0, 0);
    step(0, 8'h00, 8'h00, 1, 0, 0);
    ticks(1);
    step(0, 8'h00, 8'h00, 0, 1, 0);
    ticks(5);
    check("pause_hold", 32'({min, sec}), 32'h0002);
    step(0, 8'h00, 8'h00, 1, 0, 0);
    ticks(2);

    // sanitize and zero start
    step(1, 8'hA7, 8'h9F, 0, 0, 0);
    check("sanitize", 32'({min, sec}), 32'h5759);
    step(1, 8'h00, 8'h00, 0, 0, 0);
    step(0, 8'h00, 8'h00, 1, 0, 0);
    check("zero_start_done", 32'(done), 32'd1);

    // tick+stop together, then load+tick from expired
    step(1, 8'h00, 8'h08, 0, 0, 0);
    step(0, 8'h00, 8'h00, 1, 0, 0);
    ticks(3);
    step(0, 8'h00, 8'h00, 0, 1, 1);
    check("stop_tick_val", 32'({min, sec}), 32'h0005);
    step(0, 8'h00, 8'h00, 1, 1, 1);
    step(0, 8'h00, 8'h00, 1, 0, 0);
    ticks(5);
    step(1, 8'h02, 8'h00, 0, 0, 1);
    check("reload_val", 32'({min, sec}), 32'h0200);

    // asynchronous reset mid-count
    step(1, 8'h12, 8'h35, 0, 0, 0);
    step(0, 8'h00, 8'h00, 1, 0, 0);
    ticks(1);
    @(negedge clkin);
    reset = 1'b1;
    #1;
    model_reset();
    check("async_rst_val", 32'({min, sec}), 32'h0000);
    check("async_rst_run", 32'(running), 32'd0);
    #2 reset = 1'b0;
    ticks(3);
    step(1, 8'h00, 8'h02, 0, 0, 0);
    step(0, 8'h00, 8'h00, 1, 0, 0);
    ticks(3);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 99) < 2), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 5),
           ($urandom_range(0, 99) < 60));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
